// File: rtl/store_mn_if.sv
// Result-beat input, BRAM write port and job control between the PE array side and store_mn.
interface store_mn_if #(
  parameter int DATA_TYPE        = 16,
  parameter int NUM_PES          = 16,
  parameter int PARA_BLOCKS      = 4,
  parameter int LOG2_PARA_BLOCKS = 2
);
  localparam int WW = PARA_BLOCKS * NUM_PES * DATA_TYPE;

  logic                      i_start;
  logic [20:0]               M_DIM;
  logic [20:0]               N_DIM;
  logic                      i_res_valid;
  logic [LOG2_PARA_BLOCKS:0] i_res_blk_cnt;
  logic [WW-1:0]             i_res_data;
  logic                      o_res_ready;
  logic                      o_wr_en;
  logic [20:0]               o_wr_addr;
  logic [WW-1:0]             o_wr_data;
  logic                      o_done;

  modport master (
    output i_start, M_DIM, N_DIM, i_res_valid, i_res_blk_cnt, i_res_data,
    input  o_res_ready, o_wr_en, o_wr_addr, o_wr_data, o_done
  );

  modport slave (
    input  i_start, M_DIM, N_DIM, i_res_valid, i_res_blk_cnt, i_res_data,
    output o_res_ready, o_wr_en, o_wr_addr, o_wr_data, o_done
  );
endinterface

// File: rtl/store_mn.sv
// Packs 0..PARA_BLOCKS-block result beats into dense BRAM words, zero-padding the final word.
// A word is written the cycle after it fills; o_res_ready is low while a full word is pending.
module store_mn #(
  parameter int DATA_TYPE        = 16,
  parameter int NUM_PES          = 16,
  parameter int LOG2_PES         = 4,
  parameter int PARA_BLOCKS      = 4,
  parameter int LOG2_PARA_BLOCKS = 2
) (
  input  logic      clk,
  input  logic      rst,
  store_mn_if.slave bus
);
  localparam int BW = NUM_PES * DATA_TYPE;
  localparam int NB = 2 * PARA_BLOCKS;
  localparam int FW = LOG2_PARA_BLOCKS + 2;
  localparam int CW = LOG2_PARA_BLOCKS + 1;
  localparam logic [FW-1:0] PB_F = FW'(PARA_BLOCKS);
  localparam logic [CW-1:0] PB_C = CW'(PARA_BLOCKS);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e                        state_q, state_d;
  logic [FW-1:0]                 fill_q, fill_d;
  logic [NB-1:0][BW-1:0]         buf_q, buf_d;
  logic [20:0]                   total_q, total_d;
  logic [20:0]                   acc_q, acc_d;
  logic [20:0]                   addr_q, addr_d;

  logic [20:0]                   total_calc;
  logic [CW-1:0]                 cnt_cl;
  logic [20:0]                   rem;
  logic [20:0]                   take;
  logic                          accept;
  logic                          wr_full;
  logic [CW-1:0]                 idx;
  logic [PARA_BLOCKS-1:0][BW-1:0] in_blk;
  logic [PARA_BLOCKS-1:0][BW-1:0] wr_word;

  assign in_blk     = bus.i_res_data;
  assign total_calc = 21'((42'(bus.M_DIM) * 42'(bus.N_DIM)) >> LOG2_PES);
  assign cnt_cl     = (bus.i_res_blk_cnt > PB_C) ? PB_C : bus.i_res_blk_cnt;
  assign rem        = total_q - acc_q;
  assign take       = (21'(cnt_cl) < rem) ? 21'(cnt_cl) : rem;

  assign bus.o_res_ready = (state_q == RUN) && (fill_q < PB_F) && (acc_q < total_q);
  assign accept          = bus.i_res_valid && bus.o_res_ready;
  assign wr_full         = (state_q == RUN) && (fill_q >= PB_F);

  // The flush word keeps only the blocks still held; everything above fill reads as zero.
  always_comb begin
    wr_word = '0;
    for (int b = 0; b < PARA_BLOCKS; b++) begin
      if (state_q == RUN || (state_q == FLUSH && FW'(b) < fill_q)) begin
        wr_word[b] = buf_q[b];
      end
    end
  end

  assign bus.o_wr_en   = wr_full || (state_q == FLUSH && fill_q != '0);
  assign bus.o_wr_data = wr_word;
  assign bus.o_wr_addr = addr_q;
  assign bus.o_done    = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    total_d = total_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    idx     = '0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          total_d = total_calc;
          fill_d  = '0;
          acc_d   = '0;
          addr_d  = '0;
          buf_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr_full) begin
          for (int i = 0; i < PARA_BLOCKS; i++) buf_d[i] = buf_q[i + PARA_BLOCKS];
          for (int i = PARA_BLOCKS; i < NB; i++) buf_d[i] = '0;
          fill_d = fill_q - PB_F;
          addr_d = addr_q + 21'd1;
        end else if (accept) begin
          for (int b = 0; b < PARA_BLOCKS; b++) begin
            if (21'(b) < take) begin
              idx        = CW'(fill_q + FW'(b));
              buf_d[idx] = in_blk[b];
            end
          end
          fill_d = fill_q + FW'(take);
          acc_d  = acc_q + take;
        end else if (acc_q == total_q) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fill_q != '0) addr_d = addr_q + 21'd1;
        fill_d  = '0;
        buf_d   = '0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fill_q  <= '0;
      buf_q   <= '0;
      total_q <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: doc/store_mn.md
Name: store_MN

Overview:
- Write-side counterpart of the KN loader: drains result blocks from the PE array and packs them into full-width BRAM words for the MN result memory.
- Each input beat carries 0..PARA_BLOCKS valid blocks of NUM_PES elements, always contiguous from block 0.
- The block compacts beats across word boundaries, writes dense words at sequential addresses, and zero-pads and flushes the final partial word.

Parameters:
- DATA_TYPE, 16, bits per element
- NUM_PES, 16, elements per block
- LOG2_PES, 4, log2(NUM_PES)
- PARA_BLOCKS, 4, blocks per BRAM word
- LOG2_PARA_BLOCKS, 2, log2(PARA_BLOCKS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle job start pulse; dimensions are sampled on this cycle
- M_DIM  in  21  rows of result
- N_DIM  in  21  cols of result
- i_res_valid  in  1  beat valid
- i_res_blk_cnt  in  LOG2_PARA_BLOCKS+1  valid blocks in beat, blocks 0..cnt-1
- i_res_data  in  PARA_BLOCKS*NUM_PES*DATA_TYPE  block b at [b*NUM_PES*DATA_TYPE +: NUM_PES*DATA_TYPE]
- o_res_ready  out  1  beat accepted when valid&ready
- o_wr_en  out  1  BRAM write enable
- o_wr_addr  out  21  BRAM word address
- o_wr_data  out  PARA_BLOCKS*NUM_PES*DATA_TYPE  packed word
- o_done  out  1  job complete, level

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous, active-high.
  - rst clears: state=IDLE, fill=0, buffer=0, accepted=0, addr=0.
  - All outputs are 0 in reset and the cycle after.
  - rst mid-job discards buffered data; no write is issued.
- Storage: buffer holds 2*PARA_BLOCKS blocks; fill is LOG2_PARA_BLOCKS+2 bits; total and accepted are 21 bits.
- Job length: on i_start in IDLE or DONE, latch total = (M_DIM*N_DIM)>>LOG2_PES, truncated to 21 bits.
  - M_DIM*N_DIM must be a multiple of NUM_PES.
  - Clear fill, accepted and addr; o_done=0; go RUN.
  - i_start in RUN or FLUSH is ignored.
- Ready: o_res_ready = (state==RUN) && fill<PARA_BLOCKS && accepted<total, combinational from registers.
- Accept, on valid&ready:
  - take = min(i_res_blk_cnt, total-accepted). cnt>PARA_BLOCKS is illegal and is clamped to PARA_BLOCKS.
  - Blocks 0..take-1 are stored at buffer positions fill..fill+take-1.
  - accepted += take. cnt=0 is a no-op beat.
- Write, RUN:
  - o_wr_en = (fill>=PARA_BLOCKS); o_wr_data = buffer blocks 0..PARA_BLOCKS-1; o_wr_addr = addr. These outputs are combinational from registers.
  - On that edge the buffer shifts down by PARA_BLOCKS and addr += 1.
- Accept and write are mutually exclusive (ready requires fill<PARA_BLOCKS).
  - Latency: a beat that completes a word at edge t produces o_wr_en in the cycle after t.
- RUN -> FLUSH when accepted==total and fill<PARA_BLOCKS, i.e. no pending full word.
- FLUSH:
  - If fill>0: one cycle with o_wr_en=1, data = buffer blocks 0..fill-1 and upper blocks forced to 0; addr += 1; fill=0; go DONE.
  - If fill==0: go DONE with no write.
- DONE: o_done=1, o_res_ready=0; the state is held until i_start or rst.
- total==0: RUN immediately passes through FLUSH to DONE with no writes.
- Address wraps modulo 2^21 (not expected in use).

Test Plan (DATA_TYPE=8, NUM_PES=4, PARA_BLOCKS=4, block k filled with byte k):
- M=4, N=16 (total 16), cnt=4 every cycle -> 4 writes at addr 0..3, word n = blocks 4n..4n+3, no FLUSH write, then o_done=1.
- M=4, N=12 (total 12), cnt=3 every cycle:
  - writes addr0 {0,1,2,3}, addr1 {4..7}, addr2 {8..11};
  - ready drops for one cycle after the beat that makes fill>=4.
- M=4, N=6 (total 6), cnt=4 then cnt=2:
  - addr0 {0..3};
  - FLUSH addr1 with blocks 4,5 in the low half and the upper two blocks zero;
  - o_done=1 the cycle after.
- M=4, N=5 (total 5), cnt=4 twice -> second beat takes 1 block only; ready then 0; addr1 = {4,0,0,0}.
- Backpressure with cnt=3, cnt=3:
  - fill goes 3 -> 6; ready=0 while fill=6;
  - write at addr0, fill=2; ready reasserts the next cycle.
- rst asserted mid-job with fill=2 -> no write, o_done=0, ready=0; a fresh i_start then restarts at addr 0.
